// File: rtl/bscan_spi_pkg.sv
// Header layout and FSM encoding shared by the BSCAN-to-SPI engine.
package bscan_spi_pkg;
  localparam logic [31:0] MAGIC_DEFAULT = 32'h59A6_59A6;

  localparam int HDR_BITS  = 64;
  localparam int MAGIC_LSB = 0;
  localparam int MAGIC_W   = 32;
  localparam int LEN_LSB   = 32;
  localparam int CS_LSB    = 48;
  localparam int CS_W      = 8;
  localparam int HOLD_BIT  = 56;
  localparam int HCNT_W    = 6;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t HDR   = 2'd1;
  localparam state_t XFER  = 2'd2;
  localparam state_t DRAIN = 2'd3;
endpackage

// File: rtl/bscan_spi_bitram.sv
// 1-bit simple dual-port RAM: one write port, one registered read port, no array
// reset so it maps onto block RAM.
module bscan_spi_bitram #(
  parameter int DEPTH = 16384,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);
  logic mem_q [DEPTH];
  logic rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Synchronous read port; read-during-write returns the old contents.
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/bscan_spi_engine.sv
// JTAG user-DR to SPI command engine: parses a 64-bit header from TDI, runs a counted
// transfer on one chip select and replays the captured MISO bits on TDO.
module bscan_spi_engine
  import bscan_spi_pkg::*;
#(
  parameter int          N_CS  = 2,
  parameter int          DEPTH = 16384,
  parameter int          LEN_W = 16,
  parameter logic [31:0] MAGIC = MAGIC_DEFAULT
) (
  input  logic            DRCK,
  input  logic            RESET_N,
  input  logic            SEL,
  input  logic            SHIFT,
  input  logic            CAPTURE,
  input  logic            TDI,
  output logic            TDO,
  input  logic            MISO,
  output logic            MOSI,
  output logic [N_CS-1:0] CSB,
  output logic            BUSY,
  output logic            ERR
);
  localparam int                AW        = $clog2(DEPTH);
  localparam logic [N_CS-1:0]   CS_NONE   = {N_CS{1'b1}};
  localparam logic [N_CS-1:0]   CS_ONE    = N_CS'(1);
  localparam logic [CS_W-1:0]   CS_LIM    = CS_W'(N_CS);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(DEPTH);
  localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HDR_BITS - 1);

  state_t              state_q, state_d;
  logic [HDR_BITS-2:0] hdr_q, hdr_d;
  logic [HCNT_W-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                hold_q, hold_d;
  logic [N_CS-1:0]     csb_q, csb_d;
  logic                tdo_q, tdo_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                fwd_q, fwd_d;
  logic                fwd_bit_q, fwd_bit_d;

  logic                active_s;
  logic [HDR_BITS-1:0] hdr_word_s;
  logic [LEN_W-1:0]    hdr_len_s;
  logic [CS_W-1:0]     hdr_cs_s;
  logic [LEN_W-1:0]    bit_nxt_s;
  logic                rd_bit_s;
  logic                ram_we_s;
  logic [AW-1:0]       ram_waddr_s;
  logic [AW-1:0]       ram_raddr_s;
  logic                ram_rdata_s;

  assign active_s    = SEL & SHIFT;
  assign ram_waddr_s = bit_cnt_q[AW-1:0];

  bscan_spi_bitram #(.DEPTH(DEPTH), .AW(AW)) u_bitram (
    .clk   (DRCK),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (MISO),
    .raddr (ram_raddr_s),
    .rdata (ram_rdata_s)
  );

  // Next-state logic: header parse, transfer, drain and abort handling.
  always_comb begin
    hdr_word_s  = {TDI, hdr_q};
    hdr_len_s   = hdr_word_s[LEN_LSB +: LEN_W];
    hdr_cs_s    = hdr_word_s[CS_LSB +: CS_W];
    bit_nxt_s   = bit_cnt_q + LEN_ONE;
    rd_bit_s    = fwd_q ? fwd_bit_q : ram_rdata_s;
    state_d     = state_q;
    hdr_d       = hdr_q;
    hdr_cnt_d   = hdr_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    len_d       = len_q;
    hold_d      = hold_q;
    csb_d       = csb_q;
    err_d       = err_q;
    tdo_d       = 1'b0;
    ram_we_s    = 1'b0;
    ram_raddr_s = {AW{1'b0}};

    if (CAPTURE && SEL) begin
      state_d   = HDR;
      hdr_cnt_d = {HCNT_W{1'b0}};
      csb_d     = CS_NONE;
    end else if (!active_s && (state_q != IDLE)) begin
      state_d = IDLE;
      csb_d   = CS_NONE;
    end else if (active_s) begin
      case (state_q)
        HDR: begin
          hdr_d     = hdr_word_s[HDR_BITS-1:1];
          hdr_cnt_d = hdr_cnt_q + HCNT_ONE;
          if (hdr_cnt_q == HCNT_LAST) begin
            if (hdr_word_s[MAGIC_LSB +: MAGIC_W] != MAGIC) begin
              state_d = IDLE;
            end else if ((hdr_cs_s >= CS_LIM) || (hdr_len_s > LEN_MAX)) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else if (hdr_len_s == {LEN_W{1'b0}}) begin
              err_d   = 1'b0;
              state_d = IDLE;
              csb_d   = hdr_word_s[HOLD_BIT] ? csb_q : CS_NONE;
            end else begin
              // Switching devices releases every select and asserts the new one at once.
              err_d     = 1'b0;
              csb_d     = ~(CS_ONE << hdr_cs_s);
              len_d     = hdr_len_s;
              hold_d    = hdr_word_s[HOLD_BIT];
              bit_cnt_d = {LEN_W{1'b0}};
              state_d   = XFER;
            end
          end else begin
            state_d = HDR;
          end
        end
        XFER: begin
          ram_we_s = 1'b1;
          if (bit_cnt_q == (len_q - LEN_ONE)) begin
            // Bit 0 is loaded here and bit 1 prefetched so DRAIN starts without a gap.
            csb_d       = hold_q ? csb_q : CS_NONE;
            tdo_d       = (len_q == LEN_ONE) ? MISO : rd_bit_s;
            ram_raddr_s = AW'(1);
            bit_cnt_d   = LEN_ONE;
            state_d     = DRAIN;
          end else begin
            bit_cnt_d = bit_nxt_s;
          end
        end
        DRAIN: begin
          if (bit_cnt_q == len_q) begin
            state_d   = HDR;
            hdr_cnt_d = {HCNT_W{1'b0}};
            bit_cnt_d = {LEN_W{1'b0}};
          end else begin
            tdo_d       = rd_bit_s;
            ram_raddr_s = bit_nxt_s[AW-1:0];
            bit_cnt_d   = bit_nxt_s;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Same-edge write/read of one address forwards MISO past the read-first RAM.
    fwd_d     = ram_we_s && (ram_waddr_s == ram_raddr_s);
    fwd_bit_d = MISO;
    busy_d    = (state_d == XFER) || (state_d == DRAIN);
  end

  // State and output registers.
  always_ff @(posedge DRCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      hdr_q     <= {(HDR_BITS-1){1'b0}};
      hdr_cnt_q <= {HCNT_W{1'b0}};
      bit_cnt_q <= {LEN_W{1'b0}};
      len_q     <= {LEN_W{1'b0}};
      hold_q    <= 1'b0;
      csb_q     <= CS_NONE;
      tdo_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      fwd_q     <= 1'b0;
      fwd_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      hdr_cnt_q <= hdr_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      len_q     <= len_d;
      hold_q    <= hold_d;
      csb_q     <= csb_d;
      tdo_q     <= tdo_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      fwd_q     <= fwd_d;
      fwd_bit_q <= fwd_bit_d;
    end
  end

  assign MOSI = TDI;
  assign TDO  = tdo_q;
  assign CSB  = csb_q;
  assign BUSY = busy_q;
  assign ERR  = err_q;
endmodule
